// File: rtl/axi_lite_req_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port between NUM_REQ req/ack requesters.
// Optional watchdog (macro AXI_ARB_TIMEOUT_EN) aborts a hung transaction with DECERR.
module axi_lite_req_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              ack,
    output logic [DATA_WIDTH-1:0]           ack_rdata,
    output logic [1:0]                      ack_resp,
    output logic [ADDR_WIDTH-1:0]           awaddr,
    output logic                            awvalid,
    output logic [2:0]                      awprot,
    input  logic                            awready,
    output logic [DATA_WIDTH-1:0]           wdata,
    output logic [DATA_WIDTH/8-1:0]         wstrb,
    output logic                            wvalid,
    input  logic                            wready,
    input  logic [1:0]                      bresp,
    input  logic                            bvalid,
    output logic                            bready,
    output logic [ADDR_WIDTH-1:0]           araddr,
    output logic                            arvalid,
    output logic [2:0]                      arprot,
    input  logic                            arready,
    input  logic [DATA_WIDTH-1:0]           rdata,
    input  logic [1:0]                      rresp,
    input  logic                            rvalid,
    output logic                            rready
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_RESP,
        S_RD_REQ,
        S_RD_DATA,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]       cand, pick;
    logic                   found;

    logic [ADDR_WIDTH-1:0]  awaddr_d, araddr_d;
    logic [DATA_WIDTH-1:0]  wdata_d, ack_rdata_d;
    logic                   awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
    logic [NUM_REQ-1:0]     ack_d;
    logic [1:0]             ack_resp_d;

    logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]  wdata_arr [NUM_REQ];

    assign awprot = 3'b000;
    assign arprot = 3'b000;
    assign wstrb  = '1;

    // Unpack the per-requester address/data buses
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Round-robin search starting just after the last granted index
    always_comb begin
        found = 1'b0;
        pick  = last_q;
        cand  = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((32'(last_q) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

`ifdef AXI_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             busy;
`else
    // Watchdog disabled: the limit parameter has no effect.
    if (TIMEOUT_CYCLES == 0) begin : g_tmo_unused
    end
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_d     = grant_q;
        awaddr_d    = awaddr;
        araddr_d    = araddr;
        wdata_d     = wdata;
        awvalid_d   = awvalid;
        wvalid_d    = wvalid;
        bready_d    = bready;
        arvalid_d   = arvalid;
        rready_d    = rready;
        ack_d       = '0;
        ack_rdata_d = ack_rdata;
        ack_resp_d  = ack_resp;
`ifdef AXI_ARB_TIMEOUT_EN
        tmo_d       = tmo_q;
        busy        = state_q inside {S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_DATA};
`endif

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = pick;
                    last_d  = pick;
                    if (req_we[pick]) begin
                        state_d   = S_WR_REQ;
                        awaddr_d  = addr_arr[pick];
                        wdata_d   = wdata_arr[pick];
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_RD_REQ;
                        araddr_d  = addr_arr[pick];
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_WR_REQ: begin
                awvalid_d = awvalid && !awready;
                wvalid_d  = wvalid && !wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = S_WR_RESP;
                    bready_d = 1'b1;
                end
            end
            S_WR_RESP: begin
                if (bvalid) begin
                    state_d        = S_DONE;
                    bready_d       = 1'b0;
                    ack_resp_d     = bresp;
                    ack_rdata_d    = '0;
                    ack_d[grant_q] = 1'b1;
                end
            end
            S_RD_REQ: begin
                if (arready) begin
                    state_d   = S_RD_DATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            S_RD_DATA: begin
                if (rvalid) begin
                    state_d        = S_DONE;
                    rready_d       = 1'b0;
                    ack_resp_d     = rresp;
                    ack_rdata_d    = rdata;
                    ack_d[grant_q] = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef AXI_ARB_TIMEOUT_EN
        // Watchdog overrides whatever the channel logic decided this cycle
        if (state_q == S_IDLE) begin
            tmo_d = '0;
        end else if (busy) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
        if (busy && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1))) begin
            state_d        = S_DONE;
            awvalid_d      = 1'b0;
            wvalid_d       = 1'b0;
            bready_d       = 1'b0;
            arvalid_d      = 1'b0;
            rready_d       = 1'b0;
            ack_resp_d     = 2'b11;
            ack_rdata_d    = '0;
            ack_d          = '0;
            ack_d[grant_q] = 1'b1;
        end
`endif
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            last_q    <= IDX_W'(NUM_REQ - 1);
            grant_q   <= '0;
            awaddr    <= '0;
            araddr    <= '0;
            wdata     <= '0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            ack       <= '0;
            ack_rdata <= '0;
            ack_resp  <= 2'b00;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            awaddr    <= awaddr_d;
            araddr    <= araddr_d;
            wdata     <= wdata_d;
            awvalid   <= awvalid_d;
            wvalid    <= wvalid_d;
            bready    <= bready_d;
            arvalid   <= arvalid_d;
            rready    <= rready_d;
            ack       <= ack_d;
            ack_rdata <= ack_rdata_d;
            ack_resp  <= ack_resp_d;
        end
    end

`ifdef AXI_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// Self-checking bench for axi_lite_req_arbiter: vector table, scoreboard queue and a
// configurable-latency AXI4-Lite slave model.
module tb_axi_lite_req_arbiter;

    localparam int NR = 2;
    localparam int DW = 32;
    localparam int AW = 4;

    logic              clk, rst_n;
    logic [NR-1:0]     req, req_we, ack;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [DW-1:0]     ack_rdata, wdata, rdata;
    logic [1:0]        ack_resp, bresp, rresp;
    logic [AW-1:0]     awaddr, araddr;
    logic [2:0]        awprot, arprot;
    logic [DW/8-1:0]   wstrb;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rvalid, rready;

    axi_lite_req_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(256)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .ack(ack), .ack_rdata(ack_rdata), .ack_resp(ack_resp),
        .awaddr(awaddr), .awvalid(awvalid), .awprot(awprot), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arprot(arprot), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int acks   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave model with programmable handshake delays
    int          cfg_aw, cfg_w, cfg_ar, cfg_b, cfg_r;
    logic [31:0] cfg_rdata;
    logic [1:0]  cfg_resp;
    int          aw_wait, w_wait, ar_wait, b_cnt, r_cnt;
    logic        aw_got, w_got, ar_got, aw_n, w_n, ar_n;
    logic [AW-1:0] cap_awaddr, cap_araddr;
    logic [DW-1:0] cap_wdata;

    assign awready = awvalid && (aw_wait >= cfg_aw);
    assign wready  = wvalid  && (w_wait  >= cfg_w);
    assign arready = arvalid && (ar_wait >= cfg_ar);
    assign aw_n    = aw_got || (awvalid && awready);
    assign w_n     = w_got  || (wvalid && wready);
    assign ar_n    = ar_got || (arvalid && arready);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
            bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
            cap_awaddr <= '0; cap_araddr <= '0; cap_wdata <= '0;
        end else begin
            aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
            w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
            ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;
            if (awvalid && awready) begin aw_got <= 1'b1; cap_awaddr <= awaddr; end
            if (wvalid && wready) begin w_got <= 1'b1; cap_wdata <= wdata; end
            if (bvalid && bready) begin
                bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
            end else if (!bvalid && aw_n && w_n) begin
                if (b_cnt >= cfg_b) begin bvalid <= 1'b1; bresp <= cfg_resp; end
                else b_cnt <= b_cnt + 1;
            end
            if (arvalid && arready) begin ar_got <= 1'b1; cap_araddr <= araddr; end
            if (rvalid && rready) begin
                rvalid <= 1'b0; r_cnt <= 0;
            end else if (!rvalid && ar_n) begin
                if (r_cnt >= cfg_r) begin
                    rvalid <= 1'b1; rdata <= cfg_rdata; rresp <= cfg_resp;
                    ar_got <= 1'b0; r_cnt <= 0;
                end else begin
                    r_cnt <= r_cnt + 1;
                end
            end
        end
    end

    typedef struct {
        int          src;
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          issue;
        int          lat;
        int          aw_n, w_n, ar_n;
    } exp_t;

    typedef struct {
        int          src;
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] sdata;
        logic [1:0]  sresp;
        int          aw_d, w_d, ar_d, rsp_d;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          exp_lat;
    } vec_t;

    exp_t sb[$];

    // Scoreboard consumer: pops one expectation per ack pulse
    initial begin
        exp_t e;
        int aw_t, w_t, ar_t, b_t, r_t;
        aw_t = 0; w_t = 0; ar_t = 0; b_t = 0; r_t = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                aw_t = 0; w_t = 0; ar_t = 0; b_t = 0; r_t = 0;
            end else begin
                if (awvalid) aw_t++;
                if (wvalid) w_t++;
                if (arvalid) ar_t++;
                if (bvalid && bready) b_t++;
                if (rvalid && rready) r_t++;
                if (ack != '0) begin
                    acks++;
                    if (sb.size() == 0) begin
                        check("unexpected_ack", 32'(ack), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("ack_grant", 32'(ack), 32'(1) << e.src);
                        check("ack_rdata", ack_rdata, e.rdata);
                        check("ack_resp", 32'(ack_resp), 32'(e.resp));
                        if (e.lat >= 0) begin
                            check("latency", 32'(cyc - e.issue), 32'(e.lat));
                            check("aw_valid_cycles", 32'(aw_t), 32'(e.aw_n));
                            check("w_valid_cycles", 32'(w_t), 32'(e.w_n));
                            check("ar_valid_cycles", 32'(ar_t), 32'(e.ar_n));
                            if (e.we) begin
                                check("awaddr_seen", 32'(cap_awaddr), 32'(e.addr));
                                check("wdata_seen", cap_wdata, e.wdata);
                                check("b_handshakes", 32'(b_t), 32'd1);
                            end else begin
                                check("araddr_seen", 32'(cap_araddr), 32'(e.addr));
                                check("r_handshakes", 32'(r_t), 32'd1);
                            end
                        end
                    end
                    aw_t = 0; w_t = 0; ar_t = 0; b_t = 0; r_t = 0;
                end
            end
        end
    end

    function automatic vec_t mk(int src, logic we, logic [3:0] addr, logic [31:0] wd,
                                logic [31:0] sdata, logic [1:0] sresp,
                                int aw_d, int w_d, int ar_d, int rsp_d,
                                logic [31:0] exp_rdata, logic [1:0] exp_resp, int exp_lat);
        vec_t v;
        v.src = src; v.we = we; v.addr = addr; v.wdata = wd;
        v.sdata = sdata; v.sresp = sresp;
        v.aw_d = aw_d; v.w_d = w_d; v.ar_d = ar_d; v.rsp_d = rsp_d;
        v.exp_rdata = exp_rdata; v.exp_resp = exp_resp; v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic set_slave(input int aw_d, input int w_d, input int ar_d, input int rsp_d,
                             input logic [31:0] sdata, input logic [1:0] sresp);
        cfg_aw = aw_d; cfg_w = w_d; cfg_ar = ar_d; cfg_b = rsp_d; cfg_r = rsp_d;
        cfg_rdata = sdata; cfg_resp = sresp;
    endtask

    // One requester, one transaction; bounded wait for its ack
    task automatic run_vec(input vec_t v, input int limit);
        exp_t e;
        int n0, t;
        @(posedge clk); #1;
        set_slave(v.aw_d, v.w_d, v.ar_d, v.rsp_d, v.sdata, v.sresp);
        e.src = v.src; e.we = v.we; e.addr = v.addr; e.wdata = v.wdata;
        e.rdata = v.exp_rdata; e.resp = v.exp_resp; e.issue = cyc; e.lat = v.exp_lat;
        e.aw_n = v.we ? v.aw_d + 1 : 0;
        e.w_n  = v.we ? v.w_d + 1 : 0;
        e.ar_n = v.we ? 0 : v.ar_d + 1;
        sb.push_back(e);
        req_we[v.src] = v.we;
        req_addr[v.src*AW +: AW] = v.addr;
        req_wdata[v.src*DW +: DW] = v.wdata;
        req[v.src] = 1'b1;
        n0 = acks; t = 0;
        while (acks == n0 && t < limit) begin @(posedge clk); t++; end
        check("vec_ack_seen", 32'(acks - n0), 32'd1);
        #1 req = '0;
    endtask

    // Both requesters held: requester 0 writes, requester 1 reads, grants must alternate from 0
    task automatic run_both(input int n);
        exp_t e;
        int n0, t, base;
        @(posedge clk); #1;
        set_slave(0, 0, 0, 0, 32'h0000_0077, 2'b00);
        base = cyc;
        for (int k = 0; k < n; k++) begin
            e.src = k % 2; e.we = (k % 2 == 0);
            e.addr = e.we ? 4'h1 : 4'h3;
            e.wdata = 32'h11;
            e.rdata = e.we ? 32'h0 : 32'h77;
            e.resp = 2'b00; e.issue = base + 4*k; e.lat = 3;
            e.aw_n = e.we ? 1 : 0; e.w_n = e.we ? 1 : 0; e.ar_n = e.we ? 0 : 1;
            sb.push_back(e);
        end
        req_we = 2'b01;
        req_addr = {4'h3, 4'h1};
        req_wdata = {32'h22, 32'h11};
        req = 2'b11;
        n0 = acks; t = 0;
        while ((acks - n0) < n && t < 200) begin @(posedge clk); t++; end
        check("both_ack_count", 32'(acks - n0), 32'(n));
        #1 req = '0;
    endtask

    vec_t vt[6];

    initial begin
        int t;
        vt[0] = mk(0, 1'b1, 4'h4, 32'hA5,       32'h0,        2'b00, 0, 0, 0, 0, 32'h0,        2'b00, 3);
        vt[1] = mk(1, 1'b0, 4'h8, 32'h0,        32'h5A,       2'b00, 0, 0, 2, 0, 32'h5A,       2'b00, 5);
        vt[2] = mk(0, 1'b1, 4'hC, 32'h12345678, 32'h0,        2'b00, 2, 0, 0, 0, 32'h0,        2'b00, 5);
        vt[3] = mk(1, 1'b0, 4'h2, 32'h0,        32'hDEADBEEF, 2'b10, 0, 0, 0, 0, 32'hDEADBEEF, 2'b10, 3);
        vt[4] = mk(0, 1'b0, 4'hF, 32'h0,        32'h0BADF00D, 2'b00, 0, 0, 0, 1, 32'h0BADF00D, 2'b00, 4);
        vt[5] = mk(1, 1'b1, 4'h3, 32'hCAFE0001, 32'h0,        2'b01, 0, 1, 0, 2, 32'h0,        2'b01, 6);

        rst_n = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        set_slave(0, 0, 0, 0, 32'h0, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        check("rst_handshake_outs", 32'({awvalid, wvalid, bready, arvalid, rready, ack}), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("rst_ack_rdata", ack_rdata, 32'd0);
        check("rst_ack_resp", 32'(ack_resp), 32'd0);
        check("rst_addrs", 32'({awaddr, araddr}), 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("const_wstrb", 32'(wstrb), 32'hF);
        check("const_prot", 32'({awprot, arprot}), 32'd0);

        for (int i = 0; i < 6; i++) run_vec(vt[i], 100);

        run_both(4);

        // Reset while waiting for the write response
        @(posedge clk); #1;
        set_slave(0, 0, 0, 5, 32'h0, 2'b00);
        req_we[0] = 1'b1; req_addr[3:0] = 4'h6; req_wdata[31:0] = 32'h66; req[0] = 1'b1;
        t = 0;
        while (!bready && t < 20) begin @(posedge clk); #1; t++; end
        check("rst_mid_in_wr_resp", 32'(bready), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_outs", 32'({awvalid, wvalid, bready, arvalid, rready, ack}), 32'd0);
        check("rst_mid_awaddr", 32'(awaddr), 32'd0);
        req = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        run_both(2);

`ifdef AXI_ARB_TIMEOUT_EN
        run_vec(mk(0, 1'b1, 4'h5, 32'h55, 32'h0, 2'b00, 0, 0, 0, 1000, 32'h0, 2'b11, -1), 400);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
`endif

        repeat (5) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/axi_lite_req_arbiter.md
Name: axi_lite_req_arbiter

Overview:
- Shares one AXI4-Lite master port between NUM_REQ simple requesters, round-robin.
- Sits between internal TB/SoC requesters (CPU stub, DMA stub) and the UART-AXI bridge register slave.
- Exactly one transaction is in flight at a time.
- Converts each req/ack command into a full AW+W+B or AR+R handshake sequence.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- DATA_WIDTH, 32, AXI data width.
- ADDR_WIDTH, 4, AXI address width.
- TIMEOUT_CYCLES, 256, watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester request, held until ack
- req_we  in  NUM_REQ  1=write, 0=read
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, index i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- ack  out  NUM_REQ  one-cycle completion pulse to the granted requester
- ack_rdata  out  DATA_WIDTH  read data, valid with ack
- ack_resp  out  2  BRESP/RRESP, valid with ack
- awaddr, awvalid, awprot  out  ADDR_WIDTH/1/3  AW channel
- awready  in  1
- wdata, wstrb, wvalid  out  DATA_WIDTH/DATA_WIDTH/8/1  W channel
- wready  in  1
- bresp  in  2; bvalid  in  1; bready  out  1  B channel
- araddr, arvalid, arprot  out  ADDR_WIDTH/1/3  AR channel
- arready  in  1
- rdata  in  DATA_WIDTH; rresp  in  2; rvalid  in  1; rready  out  1  R channel

Behaviour:
- Reset (async assert, sync deassert):
  - All valids, bready, rready, ack: 0.
  - ack_rdata, ack_resp, awaddr, araddr, wdata: 0.
  - awprot = arprot = 3'b000 and wstrb = all-ones at all times.
  - Round-robin pointer (last granted) = NUM_REQ-1, so requester 0 wins first.
- FSM states:
  - IDLE: if any req, grant the first asserted index searching upward from last+1 (mod NUM_REQ). Capture we/addr/wdata into registers and update the pointer. Go to WR_REQ or RD_REQ on the next clock.
  - WR_REQ: awvalid=wvalid=1 from the same cycle. Each valid drops independently on its ready. Either order or simultaneous acceptance is legal. When both are accepted, go to WR_RESP.
  - WR_RESP: bready=1. On bvalid, latch bresp and go to DONE.
  - RD_REQ: arvalid=1. On arready, go to RD_DATA.
  - RD_DATA: rready=1. On rvalid, latch rdata/rresp and go to DONE.
  - DONE: ack[grant]=1 for exactly one cycle with ack_rdata/ack_resp valid, then back to IDLE.
- Latency with zero-wait slave: req -> ack = 4 cycles (IDLE, REQ, RESP/DATA, DONE).
- Minimum gap between back-to-back grants: 1 IDLE cycle.
- Valids never drop before their ready.
- Outputs are stable while valid=1 and ready=0.
- A req deasserted before grant is ignored; requesters must hold req until ack.
- Arbitration is evaluated only in IDLE. Requests arriving mid-transaction wait.
- All requesters asserting continuously: grants rotate 0,1,...,NUM_REQ-1,0.
- ack_rdata holds 0 after writes; ack_resp holds the last value between acks.
- Reset mid-transaction: all channel outputs drop immediately, FSM returns to IDLE, no ack is issued.

Optional Feature:
- Macro: AXI_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on leaving IDLE and increments every cycle in WR_REQ/WR_RESP/RD_REQ/RD_DATA.
  - When it reaches TIMEOUT_CYCLES, drop all valids/readies and go to DONE with ack_resp=2'b11 (DECERR) and ack_rdata=0.
  - A hung slave thus cannot deadlock the requesters.
- Undefined: no counter; the FSM waits indefinitely.

Test Plan:
- Req0 write addr 0x4 data 0xA5, slave readies=1 -> awvalid/wvalid seen 1 cycle, ack[0] on cycle 4, ack_resp=00.
- Req1 read addr 0x8, slave returns rdata 0x5A after 3-cycle arready delay -> arvalid held 3 cycles, ack[1] with ack_rdata=0x5A.
- req=2'b11 held for 4 transactions -> grant order 0,1,0,1; no ack overlap.
- Write with wready before awready (2-cycle skew) -> wvalid drops first, awvalid holds, single B handshake, one ack.
- Slave returns rresp=2'b10 -> ack_resp=2'b10 forwarded unchanged.
- rst_n asserted during WR_RESP -> all outputs 0 same cycle, no ack; next req served normally. With AXI_ARB_TIMEOUT_EN and bvalid never asserted -> ack after 256 cycles with ack_resp=2'b11.
